uart_alu_interface: RTL and testbench

- Consumer/producer stage sitting beside the UART: collects three received bytes (operand A, operand B, opcode) from the receiver, executes one ALU operation, and returns the 8-bit result through the transmitter.
- Drives the UART's tx_start/data_in from its rx_done_tick/data_out.
- Contains the ALU as a sub-module; one transaction is in flight at a time.

---
 rtl/uart_alu_interface_pkg.sv | 24 ++
 rtl/uart_alu_interface_alu.sv | 32 +++
 rtl/uart_alu_interface.sv | 131 +++++++++++++
 tb/tb_uart_alu_interface.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_interface_pkg.sv
// Shared opcode constants and FSM state encoding for the UART-attached ALU stage.
package uart_alu_interface_pkg;

  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'h20;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'h22;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'h24;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'h25;
  localparam logic [OPCODE_W-1:0] OP_XOR = 6'h26;
  localparam logic [OPCODE_W-1:0] OP_NOR = 6'h27;
  localparam logic [OPCODE_W-1:0] OP_SRA = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// Combinational ALU: wrap-around arithmetic, logic ops and shifts; flags unknown opcodes.
module alu
  import uart_alu_interface_pkg::*;
#(
  parameter int unsigned NBITS    = 8,
  parameter int unsigned NBITS_OP = 6
) (
  input  logic [NBITS-1:0]    a,
  input  logic [NBITS-1:0]    b,
  input  logic [NBITS_OP-1:0] op,
  output logic [NBITS-1:0]    result,
  output logic                invalid_op
);

  // Oversized shift amounts naturally saturate to zero / sign fill.
  always_comb begin
    result     = '0;
    invalid_op = 1'b0;
    case (op)
      NBITS_OP'(OP_ADD): result = a + b;
      NBITS_OP'(OP_SUB): result = a - b;
      NBITS_OP'(OP_AND): result = a & b;
      NBITS_OP'(OP_OR):  result = a | b;
      NBITS_OP'(OP_XOR): result = a ^ b;
      NBITS_OP'(OP_NOR): result = ~(a | b);
      NBITS_OP'(OP_SRA): result = NBITS'($signed(a) >>> b);
      NBITS_OP'(OP_SRL): result = a >> b;
      default:           invalid_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from the UART receiver, runs one ALU op and
// hands the result byte to the UART transmitter.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int unsigned NBITS    = 8,
  parameter int unsigned NBITS_OP = 6
) (
  input  logic             CLK_100MHZ,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [NBITS-1:0] rx_data,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [NBITS-1:0] tx_data,
  output logic             busy,
  output logic             op_error,
  output logic             overrun
);

  state_e              state_q, state_d;
  logic [NBITS-1:0]    a_q, a_d;
  logic [NBITS-1:0]    b_q, b_d;
  logic [NBITS_OP-1:0] op_q, op_d;
  logic [NBITS-1:0]    tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                op_error_q, op_error_d;
  logic                overrun_q, overrun_d;

  logic [NBITS-1:0]    alu_result;
  logic                alu_invalid;

  alu #(
    .NBITS    (NBITS),
    .NBITS_OP (NBITS_OP)
  ) u_alu (
    .a          (a_q),
    .b          (b_q),
    .op         (op_q),
    .result     (alu_result),
    .invalid_op (alu_invalid)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    op_error_d = op_error_q;
    overrun_d  = overrun_q;
    case (state_q)
      ST_WAIT_A: begin
        if (rx_done_tick) begin
          a_d     = rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (rx_done_tick) begin
          b_d     = rx_data;
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (rx_done_tick) begin
          op_d    = rx_data[NBITS_OP-1:0];
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        tx_data_d  = alu_result;
        op_error_d = alu_invalid;
        state_d    = ST_SEND;
        if (rx_done_tick) overrun_d = 1'b1;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
        if (rx_done_tick) overrun_d = 1'b1;
      end
      ST_WAIT_TX: begin
        // A byte landing with the tx completion starts the next transaction.
        if (tx_done_tick) begin
          state_d = ST_WAIT_A;
          if (rx_done_tick) begin
            a_d     = rx_data;
            state_d = ST_WAIT_B;
          end
        end else if (rx_done_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d == ST_CALC) || (state_d == ST_SEND) || (state_d == ST_WAIT_TX);
  end

  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      op_error_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      op_error_q <= op_error_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign op_error = op_error_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed and randomized bench for uart_alu_interface against an arithmetic reference model.
module tb_uart_alu_interface;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       op_error;
  logic       overrun;

  int         n_assert = 0;
  int         n_fail = 0;
  logic       exp_ovr = 1'b0;
  logic       exp_operr = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_alu_interface #(.NBITS(8), .NBITS_OP(6)) dut (
    .CLK_100MHZ   (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .op_error     (op_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_valid(input int op);
    int o;
    o = op % 64;
    return (o == 32) || (o == 34) || (o == 36) || (o == 37) || (o == 38) ||
           (o == 39) || (o == 3) || (o == 2);
  endfunction

  function automatic logic [7:0] ref_result(input int a, input int b, input int op);
    int r;
    int s;
    s = (a >= 128) ? a - 256 : a;
    case (op % 64)
      32:      r = a + b;
      34:      r = a - b;
      36:      r = a & b;
      37:      r = a | b;
      38:      r = a ^ b;
      39:      r = ~(a | b);
      3:       r = (b >= 8) ? ((a >= 128) ? 255 : 0) : (s >>> b);
      2:       r = (b >= 8) ? 0 : a / (1 << b);
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  task automatic send_byte(input logic [7:0] v);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = v;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // Sends B and opcode (A already taken), then checks CALC/SEND timing and the result.
  task automatic txn_tail(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit poke);
    send_byte(b);
    send_byte(op);
    if (poke) begin
      rx_done_tick = 1'b1;
      rx_data      = 8'hAA;
    end
    check("calc_no_start", tx_start, 0);
    check("calc_busy", busy, 1);
    @(negedge clk);
    rx_done_tick = 1'b0;
    if (poke) exp_ovr = 1'b1;
    exp_data  = ref_result(a, b, op);
    exp_operr = !ref_valid(op);
    check("send_start", tx_start, 1);
    check("tx_data", tx_data, exp_data);
    check("op_error", op_error, exp_operr);
    check("overrun", overrun, exp_ovr);
    @(negedge clk);
    check("start_one_cycle", tx_start, 0);
    check("tx_data_hold", tx_data, exp_data);
  endtask

  task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit poke);
    send_byte(a);
    txn_tail(a, b, op, poke);
  endtask

  task automatic finish_tx(input int gap);
    repeat (gap) @(negedge clk);
    check("wait_tx_hold", tx_data, exp_data);
    check("wait_tx_busy", busy, 1);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_start", tx_start, 0);
    check("idle_overrun", overrun, exp_ovr);
  endtask

  initial begin
    logic [7:0] ra, rb, rop;
    logic [7:0] valid_ops [8];
    valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    #2 reset = 1'b0;
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_op_error", op_error, 0);
    check("rst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    start_txn(8'h05, 8'h03, 8'h20, 1'b0); finish_tx(3);
    check("add_value", exp_data, 8'h08);
    start_txn(8'h03, 8'h05, 8'h22, 1'b0); finish_tx(1);
    check("sub_value", exp_data, 8'hFE);
    start_txn(8'h80, 8'h02, 8'h03, 1'b0); finish_tx(0);
    check("sra_value", exp_data, 8'hE0);
    start_txn(8'h80, 8'h02, 8'h02, 1'b0); finish_tx(2);
    check("srl_value", exp_data, 8'h20);
    start_txn(8'h80, 8'h09, 8'h03, 1'b0); finish_tx(1);
    check("sra_big_value", exp_data, 8'hFF);
    start_txn(8'h80, 8'h09, 8'h02, 1'b0); finish_tx(1);
    start_txn(8'h11, 8'h22, 8'h3F, 1'b0); finish_tx(1);
    check("invalid_flag", op_error, 1);
    start_txn(8'hF0, 8'h0F, 8'hE6, 1'b0); finish_tx(1);
    check("valid_clears_err", op_error, 0);

    // Byte coincident with tx completion becomes operand A.
    start_txn(8'h09, 8'h01, 8'h22, 1'b0);
    @(negedge clk);
    rx_done_tick = 1'b1; rx_data = 8'h10; tx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; tx_done_tick = 1'b0;
    check("same_cycle_busy", busy, 0);
    check("same_cycle_overrun", overrun, 0);
    txn_tail(8'h10, 8'h04, 8'h20, 1'b0); finish_tx(1);
    check("same_cycle_value", exp_data, 8'h14);

    // Reset after operand B discards the partial transaction.
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_ovr = 1'b0; exp_operr = 1'b0;
    check("midrst_tx_start", tx_start, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_op_error", op_error, 0);
    check("midrst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_start", tx_start, 0);
    start_txn(8'h01, 8'h01, 8'h20, 1'b0); finish_tx(1);
    check("midrst_value", exp_data, 8'h02);

    // Byte during WAIT_TX is dropped and sets the sticky overrun.
    start_txn(8'h05, 8'h03, 8'h24, 1'b0);
    send_byte(8'h99);
    exp_ovr = 1'b1;
    check("overrun_set", overrun, 1);
    check("overrun_still_busy", busy, 1);
    finish_tx(1);
    start_txn(8'h07, 8'h01, 8'h20, 1'b0); finish_tx(1);
    check("overrun_not_a", exp_data, 8'h08);
    check("overrun_sticky", overrun, 1);

    // Byte during CALC after a reset that cleared overrun.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_ovr = 1'b0; exp_operr = 1'b0;
    start_txn(8'h0C, 8'h0A, 8'h26, 1'b1); finish_tx(1);
    check("calc_overrun", overrun, 1);

    for (int i = 0; i < 30; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      rop = ($urandom_range(0, 9) < 8) ? valid_ops[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rop = rop | 8'hC0;
      start_txn(ra, rb, rop, 1'b0);
      finish_tx(int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
